// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder: four chained full-adder cells feeding a registered
// {c_out, sum} stage with synchronous active-low reset.

module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic c_i,
    output logic s,
    output logic c_o
);
    logic p;

    // p is the propagate term, shared by the sum and carry equations.
    assign p   = a ^ b;
    assign s   = p ^ c_i;
    assign c_o = (a & b) | (c_i & p);
endmodule

module rca_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [4:0] carry;
    logic [3:0] sum_core;

    assign carry[0] = c_in;

    // Carry ripples bit 0 -> bit 3; carry[4] is the core carry-out.
    for (genvar i = 0; i < 4; i++) begin : g_cell
        rca_fa_cell u_fa (
            .a   (x[i]),
            .b   (y[i]),
            .c_i (carry[i]),
            .s   (sum_core[i]),
            .c_o (carry[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum   <= 4'h0;
            c_out <= 1'b0;
        end else begin
            sum   <= sum_core;
            c_out <= carry[4];
        end
    end
endmodule

// File: tb/tb_rca_4bit.sv
// Directed and exhaustive checks of rca_4bit: reset, basic vectors, full ripple,
// mid-stream reset and all 512 input combinations at one-cycle latency.

module tb_rca_4bit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] x;
    logic [3:0] y;
    logic       c_in;
    logic [3:0] sum;
    logic       c_out;

    int total = 0;
    int bad   = 0;

    rca_4bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got c_out/sum=%0d/%h want %0d/%h",
                     tag, got[4], got[3:0], exp[4], exp[3:0]);
        end
    endtask

    // Apply one vector, clock it in, and check the registered result.
    task automatic vec(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [4:0] exp);
        x = a; y = b; c_in = c;
        @(posedge clk); #1;
        chk(tag, {c_out, sum}, exp);
    endtask

    initial begin
        rst_n = 1'b0; x = 4'hF; y = 4'hF; c_in = 1'b1;
        @(posedge clk); #1;
        chk("rst_edge1", {c_out, sum}, 5'h00);
        @(posedge clk); #1;
        chk("rst_edge2", {c_out, sum}, 5'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_release", {c_out, sum}, 5'h1F);

        vec("b_0_0_0", 4'h0, 4'h0, 1'b0, 5'h00);
        vec("b_1_1_0", 4'h1, 4'h1, 1'b0, 5'h02);
        vec("b_1_1_1", 4'h1, 4'h1, 1'b1, 5'h03);
        vec("b_0_0_1", 4'h0, 4'h0, 1'b1, 5'h01);

        vec("max_F_F_1", 4'hF, 4'hF, 1'b1, 5'h1F);
        vec("max_F_F_0", 4'hF, 4'hF, 1'b0, 5'h1E);

        vec("rip_F_0_0", 4'hF, 4'h0, 1'b0, 5'h0F);
        vec("rip_F_0_1", 4'hF, 4'h0, 1'b1, 5'h10);
        vec("rip_0_F_0", 4'h0, 4'hF, 1'b0, 5'h0F);
        vec("rip_0_F_1", 4'h0, 4'hF, 1'b1, 5'h10);
        vec("rip_5_A_1", 4'h5, 4'hA, 1'b1, 5'h10);

        // Inputs changing between edges must not disturb the held outputs.
        x = 4'h7; y = 4'h8; c_in = 1'b0;
        #2;
        chk("hold_between_edges", {c_out, sum}, 5'h10);
        @(posedge clk); #1;
        chk("after_hold", {c_out, sum}, 5'h0F);

        vec("mid_pre", 4'hF, 4'h0, 1'b1, 5'h10);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst", {c_out, sum}, 5'h00);
        rst_n = 1'b1;
        vec("mid_post", 4'h1, 4'h1, 1'b0, 5'h02);

        for (int i = 0; i < 512; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            logic       c;
            logic [4:0] e;
            a = i[3:0];
            b = i[7:4];
            c = i[8];
            e = 5'(a) + 5'(b) + 5'(c);
            x = a; y = b; c_in = c;
            @(posedge clk); #1;
            chk($sformatf("exh_%h_%h_%0d", a, b, c), {c_out, sum}, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
